i2s_sample_framer: RTL and testbench



---
 rtl/i2s_sample_framer.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2s_sample_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_framer.sv
// i2s_sample_framer
//    Turns the word-complete strobes of an I2S receiver into stereo sample
//    pairs.  It watches sck and ws, which are asynchronous to clk, and waits
//    SETTLE_SCK bit-clock falling edges after each ws edge so that the
//    receiver's data_left / data_right words are stable.  It then captures
//    the upper SAMPLE_WIDTH bits of each word and queues {left, right} pairs
//    in a small FIFO that has a valid/ready read port.
//
// Ports
//    clk, rst_n               system clock, async active-low reset
//    sck, ws                  raw I2S bit clock / word select (asynchronous)
//    data_left, data_right    last completed receiver words (DATA_WIDTH)
//    out_valid, out_ready     FIFO head handshake
//    out_left, out_right      head pair, two's complement (SAMPLE_WIDTH)
//    out_mono                 floor((out_left + out_right) / 2)
//    level                    number of stored pairs
//    overflow, frame_err      sticky flags, cleared by clr_flags (set wins)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ALIGN     | after reset; ignore everything until the first ws rise
// SETTLE_L  | ws rose, left word finishing; count sck falls, then latch
// WAIT_FALL | left sample held; wait for ws fall
// SETTLE_R  | ws fell, right word finishing; count sck falls, then push
// WAIT_RISE | pair handed to FIFO; wait for next ws rise
module i2s_sample_framer #(
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 24,
   parameter int FIFO_DEPTH   = 8,
   parameter int SETTLE_SCK   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sck,
   input  logic                          ws,
   input  logic [DATA_WIDTH-1:0]         data_left,
   input  logic [DATA_WIDTH-1:0]         data_right,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SAMPLE_WIDTH-1:0]       out_left,
   output logic [SAMPLE_WIDTH-1:0]       out_right,
   output logic [SAMPLE_WIDTH-1:0]       out_mono,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clr_flags
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(SETTLE_SCK + 1);

   typedef enum logic [2:0] {
      ALIGN     = 3'd0,
      SETTLE_L  = 3'd1,
      WAIT_FALL = 3'd2,
      SETTLE_R  = 3'd3,
      WAIT_RISE = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizers and edge detect
   // ------------------------------------------------------------------
   logic [1:0] sck_sync_q, ws_sync_q;
   logic       sck_prev_q, ws_prev_q;
   logic [2:0] fill_q;
   logic       sck_fall, ws_rise, ws_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         ws_prev_q  <= 1'b0;
         fill_q     <= '0;
      end else begin
         sck_sync_q <= {sck_sync_q[0], sck};
         ws_sync_q  <= {ws_sync_q[0], ws};
         sck_prev_q <= sck_sync_q[1];
         ws_prev_q  <= ws_sync_q[1];
         fill_q     <= {fill_q[1:0], 1'b1};
      end
   end

   // The pipeline resets to 0.  If ws is already high at release, the first
   // samples would look like a rise, so edges are masked until the pipeline
   // holds real samples.
   assign sck_fall = fill_q[2] &  sck_prev_q & ~sck_sync_q[1];
   assign ws_rise  = fill_q[2] & ~ws_prev_q  &  ws_sync_q[1];
   assign ws_fall  = fill_q[2] &  ws_prev_q  & ~ws_sync_q[1];

   // ------------------------------------------------------------------
   // Framing FSM
   // ------------------------------------------------------------------
   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [SAMPLE_WIDTH-1:0] left_q, right_q;
   logic                    push_q;
   logic                    frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ALIGN;
         cnt_q       <= '0;
         left_q      <= '0;
         right_q     <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (clr_flags) frame_err_q <= 1'b0;
         case (state_q)
            ALIGN: begin
               if (ws_rise) begin
                  state_q <= SETTLE_L;
                  cnt_q   <= CNT_W'(SETTLE_SCK);
               end
            end
            SETTLE_L: begin
               if (ws_rise) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= CNT_W'(SETTLE_SCK);
               end else if (ws_fall) begin
                  frame_err_q <= 1'b1;
                  state_q     <= WAIT_RISE;
               end else if (sck_fall) begin
                  if (cnt_q == CNT_W'(1)) begin
                     left_q  <= data_left[DATA_WIDTH-1 -: SAMPLE_WIDTH];
                     state_q <= WAIT_FALL;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            WAIT_FALL: begin
               if (ws_fall) begin
                  state_q <= SETTLE_R;
                  cnt_q   <= CNT_W'(SETTLE_SCK);
               end
            end
            SETTLE_R: begin
               if (ws_rise) begin
                  frame_err_q <= 1'b1;
                  state_q     <= SETTLE_L;
                  cnt_q       <= CNT_W'(SETTLE_SCK);
               end else if (ws_fall) begin
                  frame_err_q <= 1'b1;
                  state_q     <= WAIT_RISE;
               end else if (sck_fall) begin
                  if (cnt_q == CNT_W'(1)) begin
                     right_q <= data_right[DATA_WIDTH-1 -: SAMPLE_WIDTH];
                     push_q  <= 1'b1;
                     state_q <= WAIT_RISE;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            WAIT_RISE: begin
               if (ws_rise) begin
                  state_q <= SETTLE_L;
                  cnt_q   <= CNT_W'(SETTLE_SCK);
               end
            end
            default: state_q <= ALIGN;
         endcase
      end
   end

   assign frame_err = frame_err_q;

   // Receiver bits below the sample are intentionally discarded.
   generate
      if (DATA_WIDTH > SAMPLE_WIDTH) begin : g_lsb
         logic unused_lsbs;
         assign unused_lsbs = ^{data_left[DATA_WIDTH-SAMPLE_WIDTH-1:0],
                                data_right[DATA_WIDTH-SAMPLE_WIDTH-1:0]};
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stereo-pair FIFO
   // ------------------------------------------------------------------
   logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
   logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    overflow_q;
   logic                    full, pop, wr_en, ovf_evt;

   assign out_valid = (level_q != '0);
   assign full      = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en     = push_q & (~full | pop);
   assign ovf_evt   = push_q & full & ~pop;

   always_comb begin
      level_d = level_q;
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q    <= level_d;
         overflow_q <= (overflow_q & ~clr_flags) | ovf_evt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_l[wr_ptr_q] <= left_q;
         mem_r[wr_ptr_q] <= right_q;
      end
   end

   // Head is forced to zero when empty so stale storage never shows
   // (and outputs read zero during reset without resetting the array).
   logic signed [SAMPLE_WIDTH:0] mono_sum;

   assign out_left  = out_valid ? mem_l[rd_ptr_q] : '0;
   assign out_right = out_valid ? mem_r[rd_ptr_q] : '0;
   assign mono_sum  = $signed({out_left[SAMPLE_WIDTH-1], out_left})
                    + $signed({out_right[SAMPLE_WIDTH-1], out_right});
   assign out_mono  = mono_sum[SAMPLE_WIDTH:1];

   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_i2s_sample_framer.sv
module tb_i2s_sample_framer;
   localparam int DW    = 32;
   localparam int SW    = 24;
   localparam int DEPTH = 8;
   localparam int S     = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sck = 1'b0;
   logic          ws = 1'b0;
   logic [DW-1:0] data_left = '0;
   logic [DW-1:0] data_right = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [SW-1:0] out_left, out_right, out_mono;
   logic [3:0]    level;
   logic          overflow, frame_err;
   logic          clr_flags = 1'b0;

   always #5 clk = ~clk;

   i2s_sample_framer #(
      .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .SETTLE_SCK(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws),
      .data_left(data_left), .data_right(data_right),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_left(out_left), .out_right(out_right), .out_mono(out_mono),
      .level(level), .overflow(overflow), .frame_err(frame_err),
      .clr_flags(clr_flags)
   );

   int total = 0;
   int bad = 0;

   // reference model state (frame level)
   logic [SW-1:0] exp_l[$];
   logic [SW-1:0] exp_r[$];
   int            model_lvl = 0;
   bit            aligned = 0, left_ok = 0, l_short_pend = 0, r_short_pend = 0;
   bit            err_exp = 0, ovf_exp = 0;
   bit            rand_rdy = 0;
   logic [DW-1:0] cur_left = '0;
   logic [SW-1:0] mon_l, mon_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [SW-1:0] mono_of(input logic [SW-1:0] l, input logic [SW-1:0] r);
      int s;
      s = int'($signed(l)) + int'($signed(r));
      s = s >>> 1;
      return s[SW-1:0];
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_l.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got %h/%h expected no pair", out_left, out_right);
         end else begin
            mon_l = exp_l.pop_front();
            mon_r = exp_r.pop_front();
            check("pop_left", 32'(out_left), 32'(mon_l));
            check("pop_right", 32'(out_right), 32'(mon_r));
            check("pop_mono", 32'(out_mono), 32'(mono_of(mon_l, mon_r)));
            model_lvl--;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic set_ready(input logic v);
      rand_rdy = 0;
      @(posedge clk);
      #2;
      out_ready = v;
   endtask

   task automatic half_left(input logic [DW-1:0] w, input int n);
      @(negedge clk);
      data_left = $urandom();
      ws = 1'b1;
      if (!aligned) aligned = 1;
      else if (r_short_pend) err_exp = 1;
      r_short_pend = 0;
      l_short_pend = (n < S);
      left_ok = (n >= S);
      cur_left = w;
      for (int i = 0; i < n; i++) begin
         repeat (4) @(negedge clk);
         sck = 1'b1;
         if (i == S-1) data_left = w;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic half_right(input logic [DW-1:0] w, input int n, input bit pop_pulse);
      bit counted;
      @(negedge clk);
      data_right = $urandom();
      ws = 1'b0;
      counted = aligned && left_ok;
      if (aligned && l_short_pend) err_exp = 1;
      l_short_pend = 0;
      left_ok = 0;
      for (int i = 0; i < n; i++) begin
         repeat (4) @(negedge clk);
         sck = 1'b1;
         if (i == S-1) data_right = w;
         repeat (4) @(negedge clk);
         sck = 1'b0;
         if (counted && i == S-1) begin
            if (model_lvl >= DEPTH && !pop_pulse) begin
               ovf_exp = 1;
            end else begin
               exp_l.push_back(cur_left[DW-1 -: SW]);
               exp_r.push_back(w[DW-1 -: SW]);
               model_lvl++;
            end
            if (pop_pulse) begin
               // ready high exactly for the clock edge that writes this pair
               repeat (3) @(posedge clk);
               #1 out_ready = 1'b1;
               @(posedge clk);
               #1 out_ready = 1'b0;
            end
         end
      end
      r_short_pend = counted && (n < S);
   endtask

   task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nl, input int nr);
      half_left(l, nl);
      half_right(r, nr, 1'b0);
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 400;
      while (exp_l.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (20) @(negedge clk);
      if (exp_l.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_drain: got %0d pairs left expected 0", name, exp_l.size());
         exp_l.delete();
         exp_r.delete();
         model_lvl = 0;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      @(negedge clk);
   endtask

   task automatic model_reset();
      exp_l.delete();
      exp_r.delete();
      model_lvl = 0;
      aligned = 0; left_ok = 0; l_short_pend = 0; r_short_pend = 0;
      err_exp = 0; ovf_exp = 0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int nl, nr;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_level", 32'(level), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_left", 32'(out_left), 0);
      check("rst_right", 32'(out_right), 0);
      check("rst_mono", 32'(out_mono), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // basic pair and negative-sum floor
      set_ready(1'b1);
      frame(32'h12345600, 32'hFFFFFE00, 3, 3);
      drain("basic");
      check("basic_level", 32'(level), 0);
      frame(32'h80000000, 32'h7FFFFF00, 3, 3);
      drain("mono_floor");

      // randomized frames with random back-pressure and occasional short halves
      rand_rdy = 1;
      for (int k = 0; k < 20; k++) begin
         nl = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 4));
         nr = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 4));
         if (k == 19) begin nl = 3; nr = 3; end
         frame($urandom(), $urandom(), nl, nr);
      end
      set_ready(1'b1);
      drain("random");
      check("random_frame_err", 32'(frame_err), 32'(err_exp));
      check("random_level", 32'(level), 0);
      pulse_clr();
      err_exp = 0;
      check("clr_frame_err_a", 32'(frame_err), 0);

      // short right half: error, no push; next clean frame pushes
      frame(32'hAAAAAA00, 32'h55555500, 3, 1);
      frame(32'h01020300, 32'hFEDCBA00, 3, 3);
      drain("short_right");
      check("short_right_err", 32'(frame_err), 32'(err_exp));
      pulse_clr();
      err_exp = 0;
      check("clr_frame_err_b", 32'(frame_err), 0);

      // overflow: 10 frames into a depth-8 FIFO with no reader
      set_ready(1'b0);
      for (int k = 0; k < 10; k++) frame({8'(k + 1), 24'($urandom())}, $urandom(), 3, 3);
      repeat (10) @(negedge clk);
      check("ovf_level", 32'(level), 32'(model_lvl));
      check("ovf_level_full", 32'(level), DEPTH);
      check("ovf_flag", 32'(overflow), 32'(ovf_exp));
      set_ready(1'b1);
      drain("ovf");
      check("ovf_drained_level", 32'(level), 0);
      pulse_clr();
      ovf_exp = 0;
      check("clr_overflow", 32'(overflow), 0);

      // full FIFO with a pop in the push cycle
      set_ready(1'b0);
      for (int k = 0; k < DEPTH; k++) frame($urandom(), $urandom(), 3, 3);
      repeat (10) @(negedge clk);
      check("full_level", 32'(level), DEPTH);
      half_left($urandom(), 3);
      half_right($urandom(), 3, 1'b1);
      repeat (10) @(negedge clk);
      check("pushpop_level", 32'(level), DEPTH);
      check("pushpop_overflow", 32'(overflow), 0);
      set_ready(1'b1);
      drain("pushpop");

      // reset mid-frame with stored pairs
      set_ready(1'b0);
      for (int k = 0; k < 3; k++) frame($urandom(), $urandom(), 3, 3);
      repeat (10) @(negedge clk);
      check("prereset_level", 32'(level), 3);
      half_left($urandom(), 3);
      half_right($urandom(), 1, 1'b0);
      rst_n = 1'b0;
      ws = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_level", 32'(level), 0);
      check("midrst_left", 32'(out_left), 0);
      check("midrst_right", 32'(out_right), 0);
      check("midrst_mono", 32'(out_mono), 0);
      check("midrst_err", 32'(frame_err), 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      half_right($urandom(), 3, 1'b0);
      repeat (10) @(negedge clk);
      check("postrst_no_push", 32'(level), 0);
      check("postrst_err", 32'(frame_err), 0);
      set_ready(1'b1);
      frame($urandom(), $urandom(), 3, 3);
      drain("postrst");
      check("postrst_level", 32'(level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
